// File: rtl/dm_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dm_arb_pkg;

    localparam int unsigned DEF_AW    = 5;
    localparam int unsigned DEF_DW    = 32;
    localparam int unsigned DEF_DEPTH = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; prio names the master favoured on a tie.
module rr_arb2
    import dm_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic prio;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (prio == M0) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    // After any grant the other master becomes favoured.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= M0;
        end else if (|gnt) begin
            prio <= gnt[0] ? M1 : M0;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Clears data memory after reset, then arbitrates two masters onto it with
// registered read/error responses one cycle after the grant.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned AW    = DEF_AW,
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,
    output logic [AW-1:0] dm_addr,
    output logic          dm_rd,
    output logic          dm_wr,
    output logic [DW-1:0] dm_wdata,
    input  logic [DW-1:0] dm_rdata,
    output logic          init_busy
);

    localparam int unsigned CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t        state, state_nxt;
    logic [CW-1:0] init_cnt, init_cnt_nxt;
    logic [1:0]    gnt;
    logic          m0_in_range, m1_in_range;

    assign m0_in_range = (m0_addr < AW'(DEPTH));
    assign m1_in_range = (m1_addr < AW'(DEPTH));

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (state == ST_RUN),
        .req ({m1_req, m0_req}),
        .gnt (gnt)
    );

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_busy <= 1'b1;
        end else begin
            state     <= state_nxt;
            init_cnt  <= init_cnt_nxt;
            init_busy <= (state_nxt == ST_INIT);
        end
    end

    // Next state and the memory-side drive for the clear walk or the granted master.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        dm_addr      = '0;
        dm_rd        = 1'b0;
        dm_wr        = 1'b0;
        dm_wdata     = '0;
        case (state)
            ST_INIT: begin
                dm_wr        = 1'b1;
                dm_addr      = AW'(init_cnt);
                init_cnt_nxt = init_cnt + CW'(1);
                if (init_cnt == CW'(DEPTH - 1)) begin
                    state_nxt    = ST_RUN;
                    init_cnt_nxt = '0;
                end
            end
            ST_RUN: begin
                if (gnt[0]) begin
                    dm_addr  = m0_addr;
                    dm_wdata = m0_wdata;
                    dm_wr    = m0_we & m0_in_range;
                    dm_rd    = ~m0_we & m0_in_range;
                end else if (gnt[1]) begin
                    dm_addr  = m1_addr;
                    dm_wdata = m1_wdata;
                    dm_wr    = m1_we & m1_in_range;
                    dm_rd    = ~m1_we & m1_in_range;
                end
            end
        endcase
    end

    // Out-of-range reads return zero alongside the error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            m0_rvalid <= 1'b0;
            m0_err    <= 1'b0;
            m0_rdata  <= '0;
            m1_rvalid <= 1'b0;
            m1_err    <= 1'b0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= gnt[0] & ~m0_we;
            m0_err    <= gnt[0] & ~m0_in_range;
            if (gnt[0] & ~m0_we) begin
                m0_rdata <= m0_in_range ? dm_rdata : '0;
            end
            m1_rvalid <= gnt[1] & ~m1_we;
            m1_err    <= gnt[1] & ~m1_in_range;
            if (gnt[1] & ~m1_we) begin
                m1_rdata <= m1_in_range ? dm_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural 8x32 data memory.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [4:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [4:0]  dm_addr;
    logic        dm_rd, dm_wr, init_busy;
    logic [31:0] dm_wdata, dm_rdata;

    logic [31:0] mem [0:7];
    logic        pre;

    int n_checks = 0;
    int n_errors = 0;

    dm_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .m1_err    (m1_err),
        .dm_addr   (dm_addr),
        .dm_rd     (dm_rd),
        .dm_wr     (dm_wr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    assign dm_rdata = (dm_addr < 5'd8) ? mem[dm_addr[2:0]] : 32'h0;

    always @(posedge clk) begin
        if (pre) begin
            for (int i = 0; i < 8; i++) mem[i] <= 32'hDEADBEEF;
        end else if (dm_wr) begin
            mem[dm_addr[2:0]] <= dm_wdata;
        end
    end

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; pre = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 5'd0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 5'd0; m1_wdata = 32'h0;
        cyc();
        pre = 1'b0; rst = 1'b0;

        // reset values
        chk1("rst_init_busy", init_busy, 1'b1);
        chk1("rst_m0_rvalid", m0_rvalid, 1'b0);
        chk1("rst_m1_rvalid", m1_rvalid, 1'b0);
        chk1("rst_m0_err", m0_err, 1'b0);
        chk1("rst_m1_err", m1_err, 1'b0);
        chk32("rst_m0_rdata", m0_rdata, 32'h0);
        chk32("rst_m1_rdata", m1_rdata, 32'h0);

        // clear walk while m0 has a read of addr 3 pending
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 5'd3;
        for (int k = 0; k < 8; k++) begin
            settle();
            chk1("init_busy", init_busy, 1'b1);
            chk1("init_dm_wr", dm_wr, 1'b1);
            chk1("init_dm_rd", dm_rd, 1'b0);
            chk32("init_dm_addr", 32'(dm_addr), 32'(k));
            chk32("init_dm_wdata", dm_wdata, 32'h0);
            chk1("init_m0_gnt", m0_gnt, 1'b0);
            cyc();
        end
        settle();
        chk1("run_init_busy", init_busy, 1'b0);
        chk1("rd3_gnt", m0_gnt, 1'b1);
        chk1("rd3_dm_rd", dm_rd, 1'b1);
        chk32("rd3_dm_addr", 32'(dm_addr), 32'd3);
        cyc();
        chk1("rd3_rvalid", m0_rvalid, 1'b1);
        chk32("rd3_rdata", m0_rdata, 32'h0);

        // write then read back
        m0_we = 1'b1; m0_addr = 5'd5; m0_wdata = 32'h12345678;
        settle();
        chk1("wr5_gnt", m0_gnt, 1'b1);
        chk1("wr5_dm_wr", dm_wr, 1'b1);
        chk32("wr5_dm_addr", 32'(dm_addr), 32'd5);
        chk32("wr5_dm_wdata", dm_wdata, 32'h12345678);
        cyc();
        chk1("wr5_no_rvalid", m0_rvalid, 1'b0);
        m0_we = 1'b0;
        settle();
        chk1("rd5_gnt", m0_gnt, 1'b1);
        chk1("rd5_dm_rd", dm_rd, 1'b1);
        cyc();
        chk1("rd5_rvalid", m0_rvalid, 1'b1);
        chk32("rd5_rdata", m0_rdata, 32'h12345678);
        m0_req = 1'b0;

        // m1 seeds addr 1 and 2
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 5'd1; m1_wdata = 32'hAAAA0001;
        settle();
        chk1("wr1_gnt", m1_gnt, 1'b1);
        cyc();
        m1_addr = 5'd2; m1_wdata = 32'hBBBB0002;
        settle();
        chk1("wr2_gnt", m1_gnt, 1'b1);
        cyc();

        // contention: m0 reads 1, m1 reads 2, alternating from m0
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 5'd1;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 5'd2;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk1("cont_m0_gnt", m0_gnt, (i % 2) == 0);
            chk1("cont_m1_gnt", m1_gnt, (i % 2) == 1);
            chk32("cont_dm_addr", 32'(dm_addr), ((i % 2) == 0) ? 32'd1 : 32'd2);
            cyc();
            chk1("cont_m0_rvalid", m0_rvalid, (i % 2) == 0);
            chk1("cont_m1_rvalid", m1_rvalid, (i % 2) == 1);
            if ((i % 2) == 0) chk32("cont_m0_rdata", m0_rdata, 32'hAAAA0001);
            else              chk32("cont_m1_rdata", m1_rdata, 32'hBBBB0002);
        end
        m0_req = 1'b0;

        // out of range write then read on m1
        m1_we = 1'b1; m1_addr = 5'd9; m1_wdata = 32'hFFFFFFFF;
        settle();
        chk1("oor_wr_gnt", m1_gnt, 1'b1);
        chk1("oor_wr_dm_wr", dm_wr, 1'b0);
        chk1("oor_wr_dm_rd", dm_rd, 1'b0);
        cyc();
        chk1("oor_wr_err", m1_err, 1'b1);
        chk1("oor_wr_rvalid", m1_rvalid, 1'b0);
        m1_we = 1'b0; m1_addr = 5'd12;
        settle();
        chk1("oor_rd_gnt", m1_gnt, 1'b1);
        chk1("oor_rd_dm_rd", dm_rd, 1'b0);
        cyc();
        chk1("oor_rd_rvalid", m1_rvalid, 1'b1);
        chk1("oor_rd_err", m1_err, 1'b1);
        chk32("oor_rd_rdata", m1_rdata, 32'h0);
        m1_req = 1'b0;
        cyc();
        chk1("oor_err_clear", m1_err, 1'b0);

        // m0 read leaves m1 favoured across the idle stretch
        m0_req = 1'b1; m0_addr = 5'd1;
        settle();
        chk1("pre_idle_gnt", m0_gnt, 1'b1);
        cyc();
        chk32("pre_idle_rdata", m0_rdata, 32'hAAAA0001);
        m0_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk1("idle_dm_rd", dm_rd, 1'b0);
            chk1("idle_dm_wr", dm_wr, 1'b0);
            chk32("idle_dm_addr", 32'(dm_addr), 32'h0);
            chk1("idle_gnt", m0_gnt | m1_gnt, 1'b0);
            cyc();
            chk32("idle_m0_rdata", m0_rdata, 32'hAAAA0001);
            chk32("idle_m1_rdata", m1_rdata, 32'h0);
            chk1("idle_rvalid", m0_rvalid | m1_rvalid, 1'b0);
        end
        m0_req = 1'b1; m1_req = 1'b1; m1_addr = 5'd2;
        settle();
        chk1("post_idle_m1_gnt", m1_gnt, 1'b1);
        chk1("post_idle_m0_gnt", m0_gnt, 1'b0);
        cyc();
        chk1("post_idle_m1_rvalid", m1_rvalid, 1'b1);
        chk32("post_idle_m1_rdata", m1_rdata, 32'hBBBB0002);
        m1_req = 1'b0;

        // reset lands on the edge that would return m0's read
        settle();
        chk1("mid_rd_gnt", m0_gnt, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        m1_req = 1'b1;
        chk1("mid_rst_rvalid", m0_rvalid, 1'b0);
        chk32("mid_rst_rdata", m0_rdata, 32'h0);
        chk1("mid_rst_busy", init_busy, 1'b1);
        for (int k = 0; k < 8; k++) begin
            settle();
            chk32("reinit_dm_addr", 32'(dm_addr), 32'(k));
            chk1("reinit_dm_wr", dm_wr, 1'b1);
            chk1("reinit_gnt", m0_gnt | m1_gnt, 1'b0);
            chk1("reinit_busy", init_busy, 1'b1);
            cyc();
        end
        settle();
        chk1("reinit_prio_m0_gnt", m0_gnt, 1'b1);
        chk1("reinit_prio_m1_gnt", m1_gnt, 1'b0);
        cyc();
        chk1("reinit_rvalid", m0_rvalid, 1'b1);
        chk32("reinit_cleared", m0_rdata, 32'h0);
        m0_req = 1'b0; m1_req = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-master arbiter and sequencer in front of the data memory (`dm`): 8 entries × 32 bits, 5-bit address, combinational read, write on clock edge.
- After reset, it first walks every entry, writing zero.
- It then grants one request per cycle to master 0 (CPU MEM stage) or master 1 (debug/DMA port) using round-robin priority.
- Read data is registered and returned one cycle after grant.

Parameters:
- AW, 5, address width of dm and master ports
- DW, 32, data width
- DEPTH, 8, number of implemented dm entries; addresses ≥ DEPTH are out of range

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- m0_req  in  1  master 0 request; held until m0_gnt
- m0_we  in  1  master 0: 1 = write, 0 = read
- m0_addr  in  AW  master 0 address
- m0_wdata  in  DW  master 0 write data
- m0_gnt  out  1  master 0 request accepted this cycle (combinational)
- m0_rvalid  out  1  master 0 read data valid (registered pulse)
- m0_rdata  out  DW  master 0 read data (registered)
- m0_err  out  1  master 0 out-of-range access (registered pulse)
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as m0_*, for master 1
- dm_addr  out  AW  to dm addr
- dm_rd  out  1  to dm rd
- dm_wr  out  1  to dm wr
- dm_wdata  out  DW  to dm wdata
- dm_rdata  in  DW  from dm rdata
- init_busy  out  1  high while the clear sequence runs

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high. It is sampled only on posedge clk.
- Reset values:
  - state = INIT, init_cnt = 0, prio = 0 (master 0 favoured).
  - m*_rvalid = 0, m*_err = 0, m*_rdata = 0.
  - init_busy = 1.
  - gnt outputs low.
- INIT state:
  - Each cycle drives dm_wr = 1, dm_rd = 0, dm_addr = init_cnt, dm_wdata = 0.
  - init_cnt increments each cycle.
  - When init_cnt == DEPTH-1, moves to RUN on that edge and clears init_busy. The sequence takes exactly DEPTH cycles.
  - Both gnt outputs are 0 throughout; pending requests wait.
- RUN state, grant:
  - Only m0 requesting → m0 granted. Only m1 requesting → m1 granted.
  - Both requesting → master selected by prio is granted.
  - On any grant, prio becomes the non-granted master.
  - No request → prio unchanged.
- RUN state, dm drive:
  - Granted master's addr/wdata go to dm in the same cycle.
  - dm_wr = gnt & we & in_range; dm_rd = gnt & ~we & in_range.
  - No grant → dm_rd = dm_wr = 0, dm_addr = 0, dm_wdata = 0.
- Read latency: for a granted in-range read, on the following edge:
  - rdata of that master ← dm_rdata.
  - rvalid pulses high for exactly one cycle.
  - The other master's rdata is unchanged.
- Write:
  - Memory is updated at the grant edge. No rvalid is generated.
  - A read of the same address granted in the next cycle returns the new data.
- Out of range (addr ≥ DEPTH):
  - Access is granted normally, but dm_rd and dm_wr stay 0.
  - Next cycle that master's err pulses for one cycle.
  - For a read, rvalid also pulses and rdata = 0.
- Back-to-back throughput: one access per cycle. A master holding req continuously while the other also requests gets every other cycle.
- Reset mid-operation: rst in any cycle aborts everything.
  - Next cycle: state = INIT, init_cnt = 0, rvalid/err low, prio = 0.
  - The pending read result is discarded.
  - The memory clear restarts from entry 0.
- rdata holds its last value between reads; it is reset only by rst.

Decomposition:
- Package dm_arb_pkg holds:
  - state encoding ST_INIT = 1'b0, ST_RUN = 1'b1
  - master ids M0 = 1'b0, M1 = 1'b1
  - default DEPTH/AW/DW constants
- One sub-module, rr_arb2: two-requester round-robin arbiter.
  - Inputs: clk, rst, en, req[1:0].
  - Outputs: gnt[1:0] (combinational), holding the prio register.
  - en = (state == ST_RUN).

Test Plan:
- Init clear: preload dm entries with 0xDEADBEEF, assert rst 1 cycle → init_busy high exactly 8 cycles, dm_wr=1 at addr 0..7 with wdata 0; m0 read addr 3 afterwards → m0_rvalid next cycle, m0_rdata = 0.
- Write then read: m0 write addr 5 data 0x12345678, next cycle m0 read addr 5 → gnt both cycles, m0_rvalid one cycle after read grant with 0x12345678.
- Contention: m0 and m1 both hold read requests (addr 1, addr 2) for 4 cycles after init → grants m0, m1, m0, m1; rvalids alternate, each with correct data.
- Out of range: m1 write addr 9 data 0xFFFFFFFF → m1_gnt=1, dm_wr=0, m1_err pulses next cycle; m1 read addr 12 → m1_rvalid=1, m1_rdata=0, m1_err=1.
- Reset mid-read: m0 read granted, rst asserted in the following cycle → m0_rvalid stays 0, init_busy=1, clear restarts at addr 0, prio = m0.
- Idle: no req for 5 cycles in RUN → dm_rd=dm_wr=0, prio unchanged, m*_rdata holds previous value.
